// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared IFU state encoding and reset PC constant
package ifu_fetch_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        WAIT_RESP = 3'd1,
        SEND      = 3'd2,
        WAIT_PC   = 3'd3,
        HALT      = 3'd4
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - IFU memory-port and IFU/IDU handshake signal bundle
interface ifu_fetch_if;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        mem_resp_ready;
    logic        ifu_send_valid;
    logic        idu_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_write_enable;
    logic        idu_send_to_ifu_valid;
    logic        fetch_misaligned;
    logic [31:0] fetch_count;

    modport master (
        output mem_req_valid, mem_addr, mem_resp_ready,
        output ifu_send_valid, instruction, pc,
        output fetch_misaligned, fetch_count,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        input  idu_ready, pc_next, pc_write_enable, idu_send_to_ifu_valid
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_resp_ready,
        input  ifu_send_valid, instruction, pc,
        input  fetch_misaligned, fetch_count,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        output idu_ready, pc_next, pc_write_enable, idu_send_to_ifu_valid
    );

endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-issue instruction fetch FSM with registered IFU->IDU handshake
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus
);

    ifu_state_e  state, state_d;
    logic [31:0] fetch_pc, pending_pc, pc_q, instr_q, count_q;
    logic        pending;
    logic        req_valid_q, resp_ready_q, send_valid_q, misaligned_q;
    logic        req_valid_d, resp_ready_d, send_valid_d, misaligned_d;
    logic        req_fire, resp_fire, send_fire, target_ok, redirect;
    logic [31:0] target_pc;

    assign req_fire  = (state == FETCH) && req_valid_q && bus.mem_req_ready;
    assign resp_fire = (state == WAIT_RESP) && bus.mem_resp_valid;
    assign send_fire = (state == SEND) && bus.idu_ready;
    // A same-cycle strobe wins over an older pending target.
    assign target_ok = (state == WAIT_PC) && (pending || bus.pc_write_enable);
    assign target_pc = bus.pc_write_enable ? bus.pc_next : pending_pc;
    assign redirect  = (state == WAIT_PC) && (state_d == FETCH);

    always_comb begin
        state_d = state;
        case (state)
            FETCH:     if (req_fire)  state_d = WAIT_RESP;
            WAIT_RESP: if (resp_fire) state_d = SEND;
            SEND:      if (send_fire) state_d = WAIT_PC;
            WAIT_PC: begin
                if (target_ok) begin
                    if (target_pc[1:0] != 2'b00)
                        state_d = HALT;
                    else if (bus.idu_send_to_ifu_valid)
                        state_d = FETCH;
                end
            end
            HALT:      state_d = HALT;
            default:   state_d = HALT;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode.
    always_comb begin
        req_valid_d  = (state_d == FETCH);
        resp_ready_d = (state_d == WAIT_RESP);
        send_valid_d = (state_d == SEND);
        misaligned_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= FETCH;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            send_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            fetch_pc     <= RESET_PC;
            pending_pc   <= RESET_PC;
            pending      <= 1'b0;
            pc_q         <= RESET_PC;
            instr_q      <= 32'd0;
            count_q      <= 32'd0;
        end else begin
            state        <= state_d;
            req_valid_q  <= req_valid_d;
            resp_ready_q <= resp_ready_d;
            send_valid_q <= send_valid_d;
            misaligned_q <= misaligned_d;
            if (resp_fire) begin
                instr_q <= bus.mem_rdata;
                pc_q    <= fetch_pc;
            end
            if (send_fire)
                count_q <= count_q + 32'd1;
            if ((state == WAIT_PC) && bus.pc_write_enable)
                pending_pc <= bus.pc_next;
            if (redirect) begin
                fetch_pc <= target_pc;
                pending  <= 1'b0;
            end else if ((state == WAIT_PC) && bus.pc_write_enable) begin
                pending  <= 1'b1;
            end
        end
    end

    assign bus.mem_req_valid    = req_valid_q;
    assign bus.mem_addr         = fetch_pc;
    assign bus.mem_resp_ready   = resp_ready_q;
    assign bus.ifu_send_valid   = send_valid_q;
    assign bus.instruction      = instr_q;
    assign bus.pc               = pc_q;
    assign bus.fetch_misaligned = misaligned_q;
    assign bus.fetch_count      = count_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed plus randomized bench for ifu_fetch against a PC/count model
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    logic [31:0] exp_pc;
    logic [31:0] exp_count;

    ifu_fetch_if bus ();

    ifu_fetch #(.RESET_PC(RESET_PC_DEFAULT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete instruction: request, response, IDU transfer and PC write-back.
    task automatic fetch_one(input int req_stall, input int resp_delay, input int send_stall,
                             input int gap, input int permit_delay,
                             input logic [31:0] insn, input logic [31:0] npc);
        int t0;
        int k;
        k = 0;
        while (bus.mem_req_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("req_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("req_addr", bus.mem_addr, exp_pc);
        t0 = cyc;
        for (int i = 0; i < req_stall; i++) begin
            bus.mem_req_ready = 1'b0;
            tick();
            chk("req_hold_valid", 32'(bus.mem_req_valid), 32'd1);
            chk("req_hold_addr", bus.mem_addr, exp_pc);
        end
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = (resp_delay == 0);
        bus.mem_rdata      = (resp_delay == 0) ? insn : $urandom;
        tick();
        bus.mem_req_ready = 1'b0;
        chk("req_drop", 32'(bus.mem_req_valid), 32'd0);
        chk("resp_ready", 32'(bus.mem_resp_ready), 32'd1);
        chk("no_early_send", 32'(bus.ifu_send_valid), 32'd0);
        for (int i = 0; i < resp_delay; i++) begin
            bus.mem_resp_valid = 1'b0;
            bus.mem_rdata      = $urandom;
            tick();
            chk("resp_wait_ready", 32'(bus.mem_resp_ready), 32'd1);
            chk("resp_wait_send", 32'(bus.ifu_send_valid), 32'd0);
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = insn;
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = $urandom;
        chk("send_valid", 32'(bus.ifu_send_valid), 32'd1);
        chk("send_instr", bus.instruction, insn);
        chk("send_pc", bus.pc, exp_pc);
        chk("send_resp_ready", 32'(bus.mem_resp_ready), 32'd0);
        for (int i = 0; i < send_stall; i++) begin
            bus.idu_ready             = 1'b0;
            bus.pc_write_enable       = 1'b1;
            bus.pc_next               = 32'h1234_5670;
            bus.idu_send_to_ifu_valid = 1'b1;
            tick();
            chk("stall_valid", 32'(bus.ifu_send_valid), 32'd1);
            chk("stall_instr", bus.instruction, insn);
            chk("stall_pc", bus.pc, exp_pc);
            chk("stall_count", bus.fetch_count, exp_count);
        end
        bus.pc_write_enable       = 1'b0;
        bus.idu_send_to_ifu_valid = 1'b0;
        bus.idu_ready             = 1'b1;
        tick();
        bus.idu_ready = 1'b0;
        exp_count = exp_count + 32'd1;
        chk("accept_count", bus.fetch_count, exp_count);
        chk("accept_send_drop", 32'(bus.ifu_send_valid), 32'd0);
        chk("accept_no_req", 32'(bus.mem_req_valid), 32'd0);
        for (int i = 0; i < gap; i++) begin
            bus.idu_send_to_ifu_valid = 1'b1;
            bus.pc_next               = $urandom;
            tick();
            chk("gap_no_req", 32'(bus.mem_req_valid), 32'd0);
        end
        bus.pc_write_enable       = 1'b1;
        bus.pc_next               = npc;
        bus.idu_send_to_ifu_valid = (permit_delay == 0);
        tick();
        bus.pc_write_enable = 1'b0;
        bus.pc_next         = $urandom;
        if (permit_delay > 0) begin
            chk("permit_no_req", 32'(bus.mem_req_valid), 32'd0);
            for (int i = 1; i < permit_delay; i++) begin
                bus.idu_send_to_ifu_valid = 1'b0;
                tick();
                chk("permit_no_req", 32'(bus.mem_req_valid), 32'd0);
            end
            bus.idu_send_to_ifu_valid = 1'b1;
            tick();
        end
        bus.idu_send_to_ifu_valid = 1'b0;
        if (npc[1:0] != 2'b00) begin
            chk("halt_misaligned", 32'(bus.fetch_misaligned), 32'd1);
            chk("halt_req", 32'(bus.mem_req_valid), 32'd0);
            chk("halt_send", 32'(bus.ifu_send_valid), 32'd0);
            chk("halt_resp", 32'(bus.mem_resp_ready), 32'd0);
        end else begin
            chk("next_req_valid", 32'(bus.mem_req_valid), 32'd1);
            chk("next_req_addr", bus.mem_addr, npc);
            chk("loop_cycles", 32'(cyc - t0),
                32'(req_stall + 1 + resp_delay + 1 + send_stall + 1 + gap +
                    ((permit_delay > 0) ? permit_delay + 1 : 1)));
            exp_pc = npc;
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        chk({tag, "_resp_ready"}, 32'(bus.mem_resp_ready), 32'd0);
        chk({tag, "_send_valid"}, 32'(bus.ifu_send_valid), 32'd0);
        chk({tag, "_misaligned"}, 32'(bus.fetch_misaligned), 32'd0);
        chk({tag, "_count"}, bus.fetch_count, 32'd0);
        chk({tag, "_pc"}, bus.pc, RESET_PC_DEFAULT);
        chk({tag, "_addr"}, bus.mem_addr, RESET_PC_DEFAULT);
        chk({tag, "_instr"}, bus.instruction, 32'd0);
    endtask

    initial begin
        logic [31:0] npc;
        n_checks = 0;
        n_fail   = 0;
        rst                       = 1'b0;
        bus.mem_req_ready         = 1'b0;
        bus.mem_resp_valid        = 1'b0;
        bus.mem_rdata             = 32'd0;
        bus.idu_ready             = 1'b0;
        bus.pc_next               = 32'd0;
        bus.pc_write_enable       = 1'b0;
        bus.idu_send_to_ifu_valid = 1'b0;
        exp_pc    = RESET_PC_DEFAULT;
        exp_count = 32'd0;

        tick();
        tick();
        chk_reset_values("reset");
        rst = 1'b1;
        chk("release_req_low", 32'(bus.mem_req_valid), 32'd0);
        tick();
        chk("first_req", 32'(bus.mem_req_valid), 32'd1);

        fetch_one(0, 0, 0, 0, 0, 32'h0000_0013, RESET_PC_DEFAULT + 32'd4);
        fetch_one(0, 0, 0, 0, 0, 32'h0000_0013, RESET_PC_DEFAULT + 32'd8);
        chk("count_two", bus.fetch_count, 32'd2);
        fetch_one(5, 0, 0, 0, 0, $urandom, exp_pc + 32'd4);
        fetch_one(0, 2, 3, 1, 0, $urandom, exp_pc + 32'd4);
        fetch_one(0, 0, 0, 0, 4, $urandom, 32'h8000_0100);

        for (int n = 0; n < 8; n++) begin
            npc = exp_pc + (32'($urandom_range(1, 64)) << 2);
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), $urandom, npc);
        end

        fetch_one(0, 1, 0, 0, 0, $urandom, 32'h8000_0102);
        for (int i = 0; i < 4; i++) begin
            bus.pc_write_enable       = 1'b1;
            bus.pc_next               = 32'h8000_0200;
            bus.idu_send_to_ifu_valid = 1'b1;
            bus.mem_req_ready         = 1'b1;
            tick();
            chk("halt_stays_req", 32'(bus.mem_req_valid), 32'd0);
            chk("halt_stays_flag", 32'(bus.fetch_misaligned), 32'd1);
        end
        bus.pc_write_enable       = 1'b0;
        bus.idu_send_to_ifu_valid = 1'b0;
        bus.mem_req_ready         = 1'b0;

        rst = 1'b0;
        #1;
        chk("halt_reset_flag", 32'(bus.fetch_misaligned), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        exp_pc    = RESET_PC_DEFAULT;
        exp_count = 32'd0;
        chk("restart_req", 32'(bus.mem_req_valid), 32'd1);
        chk("restart_addr", bus.mem_addr, RESET_PC_DEFAULT);

        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        chk("mid_wait_resp", 32'(bus.mem_resp_ready), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_values("async");
        tick();
        rst = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hdead_beef;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("stale_resp_dropped", bus.instruction, 32'd0);
        chk("stale_no_send", 32'(bus.ifu_send_valid), 32'd0);
        fetch_one(0, 0, 0, 0, 0, 32'h0010_0093, RESET_PC_DEFAULT + 32'd4);
        chk("post_reset_count", bus.fetch_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
